// File: rtl/dvs_ravens_pkg.sv
// Shared DVS/RAVENS constants: event bus width and event FIFO arbiter defaults.
// Also holds the helper that counts grants still waiting for their FIFO write.
package dvs_ravens_pkg;

    localparam int EVENT_BITS     = 16;
    localparam int ARB_NUM_REQ    = 4;
    localparam int ARB_FREE_BITS  = 5;
    localparam int ARB_COUNT_BITS = 16;

    // Grants issued but not yet written: one in the grant stage, one in the capture stage.
    function automatic logic [1:0] in_flight_count(input logic grant_v, input logic cap_v);
        return {1'b0, grant_v} + {1'b0, cap_v};
    endfunction

endpackage

// File: rtl/dvs_fifo_bus_arbiter_if.sv
// Event FIFO arbiter bus: requests/grants, shared event bus, FIFO write side and counter.
// The arbiter uses the slave modport; the interfaces/FIFO side uses master.
interface dvs_fifo_bus_arbiter_if
    import dvs_ravens_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int FREE_BITS  = ARB_FREE_BITS,
    parameter int COUNT_BITS = ARB_COUNT_BITS
) ();

    logic                  arb_enable;
    logic [NUM_REQ-1:0]    fifo_req;
    logic [NUM_REQ-1:0]    fifo_grant;
    logic [EVENT_BITS-1:0] fifo_bus_event;
    logic [FREE_BITS-1:0]  fifo_free;
    logic                  fifo_wr_en;
    logic [EVENT_BITS-1:0] fifo_wr_data;
    logic [COUNT_BITS-1:0] event_count;

    modport slave (
        input  arb_enable, fifo_req, fifo_bus_event, fifo_free,
        output fifo_grant, fifo_wr_en, fifo_wr_data, event_count
    );

    modport master (
        output arb_enable, fifo_req, fifo_bus_event, fifo_free,
        input  fifo_grant, fifo_wr_en, fifo_wr_data, event_count
    );

endinterface

// File: rtl/dvs_rr_picker.sv
// Combinational round-robin pick: first eligible requester at or above ptr, with wrap.
// Produces the one-hot pick, its index and a found flag.
module dvs_rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [PTR_W-1:0]   pick_idx_o,
    output logic               found_o
);

    // Scan from ptr upward with wrap; the first hit wins.
    always_comb begin
        int idx;
        idx        = 0;
        pick_o     = {NUM_REQ{1'b0}};
        pick_idx_o = {PTR_W{1'b0}};
        found_o    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (!found_o && eligible_i[PTR_W'(idx)]) begin
                pick_o[PTR_W'(idx)] = 1'b1;
                pick_idx_o          = PTR_W'(idx);
                found_o             = 1'b1;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/dvs_fifo_bus_arbiter.sv
// Round-robin arbiter sharing the event FIFO write port between DVS AER interfaces.
// Pipeline: grant (t) -> bus capture (t+1) -> FIFO write (t+2); grants gated by FIFO space.
module dvs_fifo_bus_arbiter
    import dvs_ravens_pkg::*;
#(
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int FREE_BITS  = ARB_FREE_BITS,
    parameter int COUNT_BITS = ARB_COUNT_BITS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dvs_fifo_bus_arbiter_if.slave  bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic                  cap_v_q;
    logic                  wr_v_q;
    logic [EVENT_BITS-1:0] wr_data_q;
    logic [COUNT_BITS-1:0] count_q, count_d;

    logic [NUM_REQ-1:0]    eligible_s;
    logic [NUM_REQ-1:0]    pick_s;
    logic [PTR_W-1:0]      pick_idx_s;
    logic                  found_s;
    logic                  grant_v_s;
    logic [1:0]            in_flight_s;
    logic                  space_ok_s;
    logic                  issue_s;

    // The requester granted this cycle still shows its request; mask it to avoid a double grant.
    assign eligible_s  = bus.fifo_req & ~grant_q;
    assign grant_v_s   = |grant_q;
    assign in_flight_s = in_flight_count(grant_v_s, cap_v_q);
    assign space_ok_s  = bus.arb_enable && (bus.fifo_free > FREE_BITS'(in_flight_s));
    assign issue_s     = space_ok_s && found_s;

    dvs_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .eligible_i (eligible_s),
        .ptr_i      (ptr_q),
        .pick_o     (pick_s),
        .pick_idx_o (pick_idx_s),
        .found_o    (found_s)
    );

    // Next grant and round-robin pointer; pointer moves past the winner only on a grant.
    always_comb begin
        grant_d = {NUM_REQ{1'b0}};
        ptr_d   = ptr_q;
        if (issue_s) begin
            grant_d = pick_s;
            if (pick_idx_s == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = {PTR_W{1'b0}};
            end else begin
                ptr_d = pick_idx_s + PTR_W'(1);
            end
        end else begin
            grant_d = {NUM_REQ{1'b0}};
            ptr_d   = ptr_q;
        end
    end

    // Saturating write counter.
    always_comb begin
        count_d = count_q;
        if (wr_v_q && (count_q != {COUNT_BITS{1'b1}})) begin
            count_d = count_q + COUNT_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Grant register, valid pipeline, bus capture and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= {NUM_REQ{1'b0}};
            ptr_q     <= {PTR_W{1'b0}};
            cap_v_q   <= 1'b0;
            wr_v_q    <= 1'b0;
            wr_data_q <= {EVENT_BITS{1'b0}};
            count_q   <= {COUNT_BITS{1'b0}};
        end else begin
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cap_v_q <= grant_v_s;
            wr_v_q  <= cap_v_q;
            // The bus is only meaningful while the capture stage is valid.
            if (cap_v_q) begin
                wr_data_q <= bus.fifo_bus_event;
            end
            count_q <= count_d;
        end
    end

    assign bus.fifo_grant   = grant_q;
    assign bus.fifo_wr_en   = wr_v_q;
    assign bus.fifo_wr_data = wr_data_q;
    assign bus.event_count  = count_q;

endmodule

// File: doc/dvs_fifo_bus_arbiter.md
# dvs_fifo_bus_arbiter

Round-robin arbiter that shares the single event FIFO write port between NUM_REQ DVS AER-to-event interfaces on the common event bus. It collects per-interface `fifo_req`, issues a one-hot registered `fifo_grant`, captures the event the granted interface drives onto the shared bus one cycle later, and issues the FIFO write. Grants are issued only when FIFO space covers every write already in flight, so no event is lost to overflow.

## Interface
- NUM_REQ, 4, number of requesting interfaces (2..8)
- FREE_BITS, 5, width of FIFO free-entry count
- COUNT_BITS, 16, width of written-event counter
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- arb_enable  in  1  1 = grants allowed; 0 = no new grants (in-flight writes complete)
- fifo_req  in  NUM_REQ  per-interface request, bit i from interface i
- fifo_grant  out  NUM_REQ  registered one-hot grant, bit i to interface i
- fifo_bus_event  in  EVENT_BITS  shared event bus, driven by granted interface the cycle after its grant
- fifo_free  in  FREE_BITS  FIFO free entries, valid this cycle, excludes this cycle's write
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  EVENT_BITS  event written to FIFO
- event_count  out  COUNT_BITS  saturating count of FIFO writes

## Operation
- Pipeline for one event: cycle t `fifo_grant[i]`=1; t+1 interface i drives bus, arbiter registers bus into capture reg; t+2 `fifo_wr_en`=1, `fifo_wr_data`=captured event.
- Eligible set = `fifo_req` & ~`fifo_grant` (requester granted in current cycle is masked; its request deasserts one cycle late, so no double grant).
- Round-robin pointer ptr (0..NUM_REQ-1): search eligible from ptr upward with wrap; first hit i gets next-cycle grant; ptr <= (i+1) mod NUM_REQ. ptr unchanged when nothing granted.
- Space check: in_flight = grants not yet written (0..2: grant this cycle + capture stage). Next grant allowed only if arb_enable && fifo_free > in_flight (unsigned compare, in_flight zero-extended to FREE_BITS).
- At most one grant per cycle; back-to-back grants to different requesters permitted (one write per cycle sustained).
- event_count increments on each `fifo_wr_en`; saturates at 2^COUNT_BITS-1.
- No FSM beyond the 3-stage valid pipeline: grant_v (== |fifo_grant), cap_v, wr_v.

## Timing
- Reset values: fifo_grant=0, fifo_wr_en=0, fifo_wr_data=0, event_count=0, ptr=0, all valids 0.
- Request-to-grant latency: 1 cycle (req sampled at edge ending cycle t-1, grant high in t). Grant-to-write latency: 2 cycles.
- Grant held exactly one cycle; never held across cycles for same requester.
- arb_enable deassert: grants stop the next cycle; already-issued grants still capture and write.
- fifo_free=0: no grant; requests held, no state change except pipeline drain.
- Simultaneous requests: resolved by ptr only; all NUM_REQ requesters serviced within NUM_REQ grants.
- Reset mid-operation: all in-flight captures/writes discarded, no write after rst_n release until a new grant completes.
- fifo_bus_event X/Z outside capture cycles is ignored; only sampled when cap stage valid.

## Structure
- EVENT_BITS from dvs_ravens_pkg; add to package: ARB_NUM_REQ default and ARB_COUNT_BITS default constants.
- One sub-module: dvs_rr_picker (combinational: eligible vector + ptr -> one-hot pick + found flag), instanced once.
- Top holds ptr, grant register, capture register, valid pipeline, in_flight derivation, counter.

## Test plan
- Single requester: req[0]=1 at cycle 10, fifo_free=16, bus=0xABC at cycle 12 -> grant[0] cycle 11 only, wr_en cycle 13 with data 0xABC, event_count=1.
- Contention: req=4'b1111 held, ptr=0 -> grants 0,1,2,3 on consecutive cycles (requesters drop req after their grant), four writes on consecutive cycles, order preserved.
- Full: fifo_free=0 with req[2]=1 for 20 cycles -> no grant; set fifo_free=1 -> grant[2] next cycle.
- Space race: fifo_free=2, req=4'b0011 -> two grants; with fifo_free held 2 and a third req[2] -> no third grant until fifo_free>in_flight.
- Saturation: COUNT_BITS=4, 20 writes -> event_count stops at 15.
- Reset mid-flight: assert rst_n=0 the cycle after a grant -> all outputs zero immediately, no wr_en after release, ptr=0.
